moving_average_inverse: RTL
===========================

Name: moving_average_inverse

Overview:
- Reconstructs the original signed 8-bit sample stream from the running-window sum produced by the moving-average filter, so it acts as the decoder for that filter.
- Sits downstream of the filter's full-precision sum output, or on the far side of a link carrying it.
- Used for loop-back verification of the filter and for recovering raw samples at the receive end.
- Recurrence: x[n] = s[n] - s[n-1] + x[n-DEPTH], with all pre-reset history taken as zero.

Parameters:
- DATA_W, 8: width of reconstructed signed samples.
- DEPTH, 4: window length of the matching moving-average filter; legal range 2..16.
- SUM_W, DATA_W+clog2(DEPTH) = 10: width of the signed incoming window sum.

Ports:
- system1000  in  1  clock, rising edge.
- system1000_rstn  in  1  asynchronous reset, active low.
- in_valid  in  1  in_sum carries a new window sum this cycle.
- in_sum  in  SUM_W  signed window sum s[n].
- clear_err  in  1  synchronous clear of the sticky err flag.
- out_valid  out  1  one-cycle pulse: out_sample holds a new x[n].
- out_sample  out  DATA_W  signed reconstructed sample x[n].
- primed  out  1  high once DEPTH samples have been reconstructed since reset.
- err  out  1  sticky: a reconstruction saturated since the last clear or reset.

Behaviour:
- Reset (async assert, sync deassert is not required of this block):
  - out_valid=0, out_sample=0, primed=0, err=0.
  - s_prev register=0; history shift register (DEPTH x DATA_W) all 0; warm-up counter=0.
- Handshake:
  - No backpressure. Every cycle with in_valid=1 consumes in_sum.
  - in_valid=0 cycles are idle: no state changes, out_valid=0, out_sample holds its last value.
- Latency: exactly 1 cycle. in_valid at edge k gives out_valid=1 and the new out_sample after edge k+1. Back-to-back in_valid yields back-to-back out_valid.
- Arithmetic:
  - d = in_sum - s_prev + hist[DEPTH-1], computed at SUM_W+2 bits, signed, without truncation.
  - If d > 2^(DATA_W-1)-1, x = max; if d < -2^(DATA_W-1), x = min; otherwise x = d.
- State update on in_valid:
  - s_prev <= in_sum.
  - History shifts: hist[0] <= x, hist[i] <= hist[i-1].
  - The saturated x is stored, so the history matches what was output.
- Warm-up counter:
  - Counts accepted samples and saturates at DEPTH.
  - primed rises in the same cycle as the DEPTH-th out_valid and stays high until reset.
  - Output before primed is still exact, because zero history is correct after reset.
- err:
  - Set in the cycle its out_valid is asserted when saturation occurred.
  - Cleared by clear_err=1 on an edge.
  - If set and clear occur on the same edge, set wins.
- Reset mid-stream: state is discarded immediately. The next in_sum is treated as s[0] with zero history. The pending output is lost and out_valid drops asynchronously.
- in_sum wrap: the input is never wrapped; out-of-range results are handled only by saturation.

Decomposition:
- Shared package:
  - DATA_W/DEPTH defaults and the SUM_W derivation function (clog2).
  - Signed sample and sum typedefs.
  - Saturation function (wide to DATA_W).
- The filter and this block both use the package so their widths match.
- One sub-module is natural: moving_average_history, the DEPTH-deep shift register with enable, exposing its tap hist[DEPTH-1]. The top level holds the arithmetic, s_prev, the counter and the flags.

Test Plan:
- Ramp, DEPTH=4: sums 1,3,6,10,14 on consecutive in_valid cycles -> out_sample 1,2,3,4,5, each one cycle later; primed rises with the 4th output.
- Negative full-scale: sums -128,-256,-384,-512,-512 -> outputs -128 x5, err stays 0.
- Saturation: after reset, sums 100 then 300 -> outputs 100 then 127 with err=1. Assert clear_err on the same edge as another saturating sum -> err stays 1. A later clear_err with no saturation -> err=0.
- Valid gaps: sums 1,3,6 with 2 idle cycles between each -> outputs 1,2,3; out_valid pulses exactly once per input; out_sample holds during gaps.
- Reset mid-stream: after outputs 1,2, assert rstn low for 1 cycle; then sum 5 -> output 5 (history cleared), primed=0, err=0.
- Loop-back: random 8-bit stream through the moving-average filter's sum path, then this block -> output equals the input delayed by the combined latency over 10k samples, err never set.

Source files
------------

// File: rtl/moving_average_inverse_pkg.sv
// Shared widths, sample/sum types and saturation helper for the moving-average
// filter and its inverse, so both ends of a link agree on SUM_W.
package moving_average_inverse_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 4;

   function automatic int sum_w(input int data_w, input int depth);
      return data_w + $clog2(depth);
   endfunction

   localparam int SUM_W_DEF = sum_w(DATA_W_DEF, DEPTH_DEF);

   typedef logic signed [DATA_W_DEF-1:0] sample_t;
   typedef logic signed [SUM_W_DEF-1:0]  sum_t;

   // Clamp a wide signed value into the signed range of a data_w-bit sample.
   function automatic logic signed [31:0] saturate(input logic signed [31:0] d,
                                                   input int data_w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (data_w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (data_w - 1));
      if (d > hi)      return hi;
      else if (d < lo) return lo;
      else             return d;
   endfunction

endpackage

// File: rtl/moving_average_history.sv
// DEPTH-deep shift register of reconstructed samples; tap is the oldest entry,
// i.e. x[n-DEPTH] at the time the next sample is computed.
module moving_average_history
   import moving_average_inverse_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] din,
   output logic signed [DATA_W-1:0] tap
);

   logic signed [DATA_W-1:0] hist [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      end else if (en) begin
         hist[0] <= din;
         for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
      end
   end

   assign tap = hist[DEPTH-1];

endmodule

// File: rtl/moving_average_inverse.sv
// Recovers samples from a moving-average window sum:
// x[n] = sat(s[n] - s[n-1] + x[n-DEPTH]), one cycle of latency.
module moving_average_inverse
   import moving_average_inverse_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int SUM_W  = sum_w(DATA_W, DEPTH)
) (
   input  logic                     system1000,
   input  logic                     system1000_rstn,
   input  logic                     in_valid,
   input  logic signed [SUM_W-1:0]  in_sum,
   input  logic                     clear_err,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_sample,
   output logic                     primed,
   output logic                     err
);

   // Handshake: no backpressure. A cycle with in_valid=1 consumes in_sum and
   // produces a one-cycle out_valid pulse on the next cycle; in_valid=0 cycles
   // leave all state untouched and out_sample holds.

   localparam int WIDE  = SUM_W + 2;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic signed [SUM_W-1:0]  s_prev;
   logic signed [DATA_W-1:0] tap;
   logic signed [WIDE-1:0]   d_wide;
   logic signed [31:0]       d32;
   logic signed [31:0]       sat32;
   logic signed [DATA_W-1:0] x;
   logic                     sat_hit;
   logic [CNT_W-1:0]         cnt;

   always_comb begin
      d_wide  = WIDE'(in_sum) - WIDE'(s_prev) + WIDE'(tap);
      d32     = 32'(d_wide);
      sat32   = saturate(d32, DATA_W);
      x       = sat32[DATA_W-1:0];
      sat_hit = (sat32 != d32);
   end

   // The saturated value is what goes into history, so later outputs track
   // what was actually emitted.
   moving_average_history #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_history (
      .clk   (system1000),
      .rst_n (system1000_rstn),
      .en    (in_valid),
      .din   (x),
      .tap   (tap)
   );

   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         s_prev     <= '0;
         out_valid  <= 1'b0;
         out_sample <= '0;
         cnt        <= '0;
         err        <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            s_prev     <= in_sum;
            out_sample <= x;
            if (cnt != CNT_W'(DEPTH)) cnt <= cnt + CNT_W'(1);
         end
         // Set has priority over a simultaneous clear.
         if (in_valid && sat_hit) err <= 1'b1;
         else if (clear_err)      err <= 1'b0;
      end
   end

   assign primed = (cnt == CNT_W'(DEPTH));

endmodule
